tdm_frame_ctrl: RTL

TDM_FRAME_CTRL -- requirements
Module: tdm_frame_ctrl

---
 rtl/tdm_frame_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/tdm_frame_ctrl.sv
// TDM frame controller: divides clk down to a bit clock, walks bit and slot
// counters through a frame of N slots, and emits frame sync plus slot/frame
// start strobes. Slot count and frame-sync style are taken at each frame start.
//
// Handshake: there is no valid/ready pair here; enable is a level request.
// A rising request starts a frame on the very next clk edge, and a falling
// request only takes effect once the frame in flight has finished.
module tdm_frame_ctrl #(
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] tdm_num,
    input  logic       fs_mode,
    output logic       bclk,
    output logic       fs,
    output logic [3:0] slot_idx,
    output logic [4:0] bit_idx,
    output logic       slot_start,
    output logic       frame_start,
    output logic       busy,
    output logic       cfg_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(SLOT_BITS - 1);

    state_t     state;
    logic [7:0] div;
    logic [4:0] n_slots;
    logic       mode_q;

    logic       new_illegal;
    logic [4:0] new_n;
    logic       div_tc;
    logic       bclk_fall;
    logic       bit_wrap;
    logic       frame_wrap;
    logic [4:0] nxt_bit;
    logic [3:0] nxt_slot;
    logic       fs_nxt;

    // Decode the slot-count code presented on tdm_num; unknown codes fall back to 2 slots.
    always_comb begin
        new_n       = 5'd2;
        new_illegal = 1'b0;
        case (tdm_num)
            4'd1:    new_n = 5'd2;
            4'd2:    new_n = 5'd4;
            4'd3:    new_n = 5'd8;
            4'd4:    new_n = 5'd16;
            default: new_illegal = 1'b1;
        endcase
    end

    // Work out where the counters go next and whether this clk closes the frame.
    always_comb begin
        div_tc     = (div == DIV_LAST);
        bclk_fall  = div_tc && bclk;
        bit_wrap   = bclk_fall && (bit_idx == BIT_LAST);
        frame_wrap = bit_wrap && ({1'b0, slot_idx} == (n_slots - 5'd1));
        nxt_bit    = bit_idx;
        nxt_slot   = slot_idx;
        if (bclk_fall) begin
            if (bit_idx == BIT_LAST) begin
                nxt_bit  = 5'd0;
                nxt_slot = slot_idx + 4'd1;
            end else begin
                nxt_bit = bit_idx + 5'd1;
            end
        end
        // Pulse mode marks only the first bit of the frame; 50% mode covers the first half of the slots.
        if (mode_q) begin
            fs_nxt = ({1'b0, nxt_slot} < (n_slots >> 1));
        end else begin
            fs_nxt = (nxt_slot == 4'd0) && (nxt_bit == 5'd0);
        end
    end

    // Control FSM with every output registered; frame boundaries reload the configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div         <= 8'd0;
            bclk        <= 1'b0;
            fs          <= 1'b0;
            slot_idx    <= 4'd0;
            bit_idx     <= 5'd0;
            slot_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
            n_slots     <= 5'd2;
            mode_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div         <= 8'd0;
                    bclk        <= 1'b0;
                    fs          <= 1'b0;
                    slot_idx    <= 4'd0;
                    bit_idx     <= 5'd0;
                    slot_start  <= 1'b0;
                    frame_start <= 1'b0;
                    busy        <= 1'b0;
                    if (enable) begin
                        // First clk of the first frame: fs is high in both modes here.
                        state       <= RUN;
                        busy        <= 1'b1;
                        fs          <= 1'b1;
                        slot_start  <= 1'b1;
                        frame_start <= 1'b1;
                        n_slots     <= new_n;
                        mode_q      <= fs_mode;
                        cfg_err     <= new_illegal;
                    end
                end
                RUN, DRAIN: begin
                    if (frame_wrap) begin
                        div      <= 8'd0;
                        bclk     <= 1'b0;
                        slot_idx <= 4'd0;
                        bit_idx  <= 5'd0;
                        if (enable) begin
                            // Next frame starts; a legal code here never clears a sticky error.
                            state       <= RUN;
                            busy        <= 1'b1;
                            fs          <= 1'b1;
                            slot_start  <= 1'b1;
                            frame_start <= 1'b1;
                            n_slots     <= new_n;
                            mode_q      <= fs_mode;
                            if (new_illegal) begin
                                cfg_err <= 1'b1;
                            end
                        end else begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            fs          <= 1'b0;
                            slot_start  <= 1'b0;
                            frame_start <= 1'b0;
                        end
                    end else begin
                        if ((state == RUN) && !enable) begin
                            state <= DRAIN;
                        end
                        div         <= div_tc ? 8'd0 : (div + 8'd1);
                        if (div_tc) begin
                            bclk <= ~bclk;
                        end
                        bit_idx     <= nxt_bit;
                        slot_idx    <= nxt_slot;
                        fs          <= fs_nxt;
                        slot_start  <= bit_wrap;
                        frame_start <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
